calc2_top_core: RTL and testbench
=================================

// Module: calc2_top_core
// PURPOSE
// - Four-port 32-bit integer calculator. Each requester port issues tagged two-cycle requests (add/sub/shift).
// - Requests queue per port; one shared add/sub unit and one shared shift unit serve them.
// - Each result returns on the originating port with its tag and a response code. Sits behind four independent requesters.
// PARAMETERS
// - DATA_W      32  operand/result width
// - FIFO_DEPTH  4   per-port request queue depth (one entry per 2-bit tag)
// PORTS
// - c_clk                 in   1   clock, rising edge
// - reset                 in   1   synchronous, active-high reset
// - reqN_cmd_in  (N=1..4) in   4   command; 0=idle, 1=add, 2=sub, 5=shl, 6=shr
// - reqN_data_in (N=1..4) in   32  operand1 on command cycle, operand2 on the next cycle
// - reqN_tag_in  (N=1..4) in   2   request tag, sampled on command cycle
// - out_respN    (N=1..4) out  2   0=none, 1=success, 2=overflow/underflow/invalid cmd, 3=reserved (never driven)
// - out_dataN    (N=1..4) out  32  result; 0 when resp is not 1
// - out_tagN     (N=1..4) out  2   tag of the completed request
// BEHAVIOUR
// - Reset (held >=1 edge): all out_* = 0; FIFOs, capture state and pipelines cleared; in-flight requests dropped without response.
// - Capture: edge sampling cmd!=0 latches cmd, tag, operand1. Next edge latches operand2; cmd is ignored on that cycle.
//   The completed request is then pushed into the port FIFO.
// - Full FIFO: a push into a full FIFO discards the request, with no response.
//   Requesters keep <=FIFO_DEPTH requests outstanding per port.
// - Dispatch: each port pops at most one FIFO head per cycle.
//   Add/sub and invalid cmds go to the add unit; shl/shr go to the shift unit.
//   Each unit accepts one request per cycle. Port selection is round-robin per unit, starting at port 1 after reset.
//   Consequence: responses per port stay in request order.
// - Uncontended latency: response is registered and visible for exactly one cycle.
//   It appears after the 3rd rising edge following the edge that sampled operand2.
//   Edge+1 pushes to the FIFO, edge+2 dispatches to the unit register, edge+3 loads the output register.
// - Idle port outputs: resp=0, data=0, tag=0.
// - add: 33-bit sum. Carry out gives resp=2, data=0; otherwise resp=1, data=sum[31:0].
// - sub: op2>op1 gives resp=2 (underflow), data=0; otherwise resp=1, data=op1-op2 (equal operands give 0, success).
// - shl/shr: logical shift of op1 by op2[4:0]; high bits of op2 are ignored; always resp=1.
// - Simultaneous: all four ports may complete in the same cycle.
//   An add and a shift from different ports dispatch in the same cycle.
// - Reset asserted mid-request (between operand cycles) abandons that request.
// CONFIGURATION
// - CALC2_INVALID_CMD_RESP_EN defined: cmds 3,4,7..15 are captured and queued.
//   They answer resp=2, data=0 with their tag at normal latency.
// - CALC2_INVALID_CMD_RESP_EN undefined: invalid cmds are still consumed for two cycles, then silently dropped.
//   They are not queued and get no response.
// STRUCTURE
// - Package calc2_pkg: cmd_e enum (IDLE, ADD, SUB, SHL, SHR), resp_e enum (NONE, OK, ERR, RSVD).
//   Also holds the request struct {cmd, tag, op1, op2} and DATA_W / FIFO_DEPTH constants.
// - Sub-module calc2_port_ctl, instantiated 4x: two-cycle capture plus FIFO, with head/pop interface.
// - Top level holds the two round-robin arbiters, the two ALU units and the output registers.
// TESTING
// - Port1: add op1=0x30, op2=0x20, tag=1.
//   -> out_resp1=1, out_data1=0x50, out_tag1=1, 3 cycles after operand2, for one cycle.
// - Port2: add 0xFFFFFFFF+0x1, tag=2 -> out_resp2=2, out_data2=0. Sub 0x5-0x6 -> resp=2. Sub 0x6-0x6 -> resp=1, data=0.
// - Port3: shl 0x1 by 0x1F -> data 0x80000000. shr 0x80000000 by 0x24 (uses 4) -> 0x08000000. Both resp=1.
// - All ports add same cycle, tags 0..3 -> four responses on consecutive cycles in order port1,2,3,4.
//   Mixed: port1 add + port2 shl -> both respond same cycle.
// - Port4: four back-to-back requests, tags 0..3 -> four responses in tag order. A fifth while full -> no response.
// - Reset asserted between operand1 and operand2 -> no response ever. All outputs 0 on the cycle after the reset edge.
// - With CALC2_INVALID_CMD_RESP_EN: cmd 3, tag 3 -> resp=2, tag=3. Without it: no response.

Source files
------------

// File: rtl/calc2_pkg.sv
// Shared types and constants for the four-port calc2 calculator.
package calc2_pkg;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_PORTS  = 4;
  localparam int TAG_W      = 2;
  localparam int SH_W       = $clog2(DATA_W);

  typedef enum logic [3:0] {
    IDLE = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0, OK = 2'd1, ERR = 2'd2, RSVD = 2'd3
  } resp_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    logic              vld;
    logic [1:0]        port;
    logic [TAG_W-1:0]  tag;
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } rsp_t;

  function automatic logic is_shift(cmd_e c);
    return (c == SHL) || (c == SHR);
  endfunction

  function automatic logic is_known(logic [3:0] c);
    return (c == ADD) || (c == SUB) || (c == SHL) || (c == SHR);
  endfunction

  // Round-robin pick: returns {valid, index}, searching upward from ptr.
  function automatic logic [2:0] rr_pick(logic [NUM_PORTS-1:0] req, logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/calc2_if.sv
// Requester-side bus of calc2_top_core: four request ports in, four response ports out.
interface calc2_if;
  import calc2_pkg::*;
  logic [3:0]        req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [TAG_W-1:0]  req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in;
  logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
  logic [TAG_W-1:0]  out_tag1,  out_tag2,  out_tag3,  out_tag4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
           req1_data_in, req2_data_in, req3_data_in, req4_data_in,
           req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
           out_data1, out_data2, out_data3, out_data4,
           out_tag1, out_tag2, out_tag3, out_tag4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
           req1_data_in, req2_data_in, req3_data_in, req4_data_in,
           req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
           out_data1, out_data2, out_data3, out_data4,
           out_tag1, out_tag2, out_tag3, out_tag4
  );
endinterface

// File: rtl/calc2_port_ctl.sv
// Per-port two-cycle request capture plus request FIFO with head/pop interface.
// CALC2_INVALID_CMD_RESP_EN: queue unknown commands so they get an error response.
module calc2_port_ctl
  import calc2_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              pop,
  output req_t              head,
  output logic              head_vld
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic              busy;
  logic [3:0]        cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] op1_q;
  req_t              pend;
  logic              pend_vld;
  logic              keep;

  req_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              full, push;

`ifdef CALC2_INVALID_CMD_RESP_EN
  assign keep = 1'b1;
`else
  assign keep = is_known(cmd_q);
`endif

  // The cycle after a command always carries operand2, whatever cmd shows.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cmd_q    <= '0;
      tag_q    <= '0;
      op1_q    <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      pend_vld <= 1'b0;
      if (busy) begin
        busy     <= 1'b0;
        pend_vld <= keep;
        pend     <= '{cmd: cmd_e'(cmd_q), tag: tag_q, op1: op1_q, op2: data_in};
      end else if (cmd_in != 4'd0) begin
        busy  <= 1'b1;
        cmd_q <= cmd_in;
        tag_q <= tag_in;
        op1_q <= data_in;
      end
    end
  end

  // Full is judged on the registered count; a same-cycle pop does not make room.
  assign full     = (cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign push     = pend_vld && !full;
  assign head     = mem[rd_ptr];
  assign head_vld = (cnt != '0);

  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr] <= pend;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule

// File: rtl/calc2_top_core.sv
// Four-port calculator core: per-port capture/FIFO, round-robin add and shift units, output registers.
// CALC2_INVALID_CMD_RESP_EN (see calc2_port_ctl) enables error responses for unknown commands.
module calc2_top_core
  import calc2_pkg::*;
(
  input  logic c_clk,
  input  logic reset,
  calc2_if.slave bus
);
  logic [NUM_PORTS-1:0][3:0]        cmd_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_in;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  tag_in;
  req_t [NUM_PORTS-1:0]             head;
  logic [NUM_PORTS-1:0]             head_vld, pop, a_req, s_req;

  logic [NUM_PORTS-1:0][1:0]        out_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  out_tag;

  logic [1:0]    a_ptr, s_ptr, a_sel, s_sel;
  logic          a_vld, s_vld;
  logic [DATA_W:0] a_sum;
  rsp_t          a_nxt, s_nxt, a_q, s_q;

  assign cmd_in  = {bus.req4_cmd_in,  bus.req3_cmd_in,  bus.req2_cmd_in,  bus.req1_cmd_in};
  assign data_in = {bus.req4_data_in, bus.req3_data_in, bus.req2_data_in, bus.req1_data_in};
  assign tag_in  = {bus.req4_tag_in,  bus.req3_tag_in,  bus.req2_tag_in,  bus.req1_tag_in};

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    calc2_port_ctl u_port (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd_in   (cmd_in[gi]),
      .data_in  (data_in[gi]),
      .tag_in   (tag_in[gi]),
      .pop      (pop[gi]),
      .head     (head[gi]),
      .head_vld (head_vld[gi])
    );
    // Unknown commands ride the add unit, which answers them with ERR.
    assign a_req[gi] = head_vld[gi] && !is_shift(head[gi].cmd);
    assign s_req[gi] = head_vld[gi] &&  is_shift(head[gi].cmd);
  end

  assign {a_vld, a_sel} = rr_pick(a_req, a_ptr);
  assign {s_vld, s_sel} = rr_pick(s_req, s_ptr);

  always_comb begin
    pop = '0;
    if (a_vld) pop[a_sel] = 1'b1;
    if (s_vld) pop[s_sel] = 1'b1;
  end

  always_comb begin
    a_sum      = {1'b0, head[a_sel].op1} + {1'b0, head[a_sel].op2};
    a_nxt      = '0;
    a_nxt.vld  = a_vld;
    a_nxt.port = a_sel;
    a_nxt.tag  = head[a_sel].tag;
    a_nxt.resp = ERR;
    case (head[a_sel].cmd)
      ADD: if (!a_sum[DATA_W]) begin
        a_nxt.resp = OK;
        a_nxt.data = a_sum[DATA_W-1:0];
      end
      SUB: if (head[a_sel].op1 >= head[a_sel].op2) begin
        a_nxt.resp = OK;
        a_nxt.data = head[a_sel].op1 - head[a_sel].op2;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_nxt      = '0;
    s_nxt.vld  = s_vld;
    s_nxt.port = s_sel;
    s_nxt.tag  = head[s_sel].tag;
    s_nxt.resp = OK;
    s_nxt.data = (head[s_sel].cmd == SHL) ? (head[s_sel].op1 << head[s_sel].op2[SH_W-1:0])
                                          : (head[s_sel].op1 >> head[s_sel].op2[SH_W-1:0]);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      a_q   <= '0;
      s_q   <= '0;
      a_ptr <= '0;
      s_ptr <= '0;
    end else begin
      a_q <= a_nxt;
      s_q <= s_nxt;
      if (a_vld) a_ptr <= a_sel + 2'd1;
      if (s_vld) s_ptr <= s_sel + 2'd1;
    end
  end

  // The two units never target the same port in one cycle: a port pops at most once.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_resp[p] <= NONE;
        out_data[p] <= '0;
        out_tag[p]  <= '0;
        if (a_q.vld && a_q.port == 2'(p)) begin
          out_resp[p] <= a_q.resp;
          out_data[p] <= a_q.data;
          out_tag[p]  <= a_q.tag;
        end
        if (s_q.vld && s_q.port == 2'(p)) begin
          out_resp[p] <= s_q.resp;
          out_data[p] <= s_q.data;
          out_tag[p]  <= s_q.tag;
        end
      end
    end
  end

  assign bus.out_resp1 = out_resp[0];
  assign bus.out_resp2 = out_resp[1];
  assign bus.out_resp3 = out_resp[2];
  assign bus.out_resp4 = out_resp[3];
  assign bus.out_data1 = out_data[0];
  assign bus.out_data2 = out_data[1];
  assign bus.out_data3 = out_data[2];
  assign bus.out_data4 = out_data[3];
  assign bus.out_tag1  = out_tag[0];
  assign bus.out_tag2  = out_tag[1];
  assign bus.out_tag3  = out_tag[2];
  assign bus.out_tag4  = out_tag[3];
endmodule

// File: tb/tb_calc2_top_core.sv
// Directed bench for calc2_top_core; responses compared as {resp, tag, data}.
module tb_calc2_top_core;
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  calc2_if bus ();
  calc2_top_core dut (.c_clk(c_clk), .reset(reset), .bus(bus));

  always #5 c_clk = ~c_clk;

  function automatic logic [35:0] rsp(input int p);
    case (p)
      1:       return {bus.out_resp1, bus.out_tag1, bus.out_data1};
      2:       return {bus.out_resp2, bus.out_tag2, bus.out_data2};
      3:       return {bus.out_resp3, bus.out_tag3, bus.out_data3};
      default: return {bus.out_resp4, bus.out_tag4, bus.out_data4};
    endcase
  endfunction

  // Response logger for the contention scenario; cleared while mon_en is low.
  logic        mon_en = 1'b0;
  int          rcnt [4];
  logic [35:0] rlog [4][8];
  always @(negedge c_clk) begin
    for (int q = 0; q < 4; q++) begin
      logic [35:0] r;
      r = rsp(q + 1);
      if (!mon_en) rcnt[q] = 0;
      else if (r[35:34] != 2'd0) begin
        if (rcnt[q] < 8) rlog[q][rcnt[q]] = r;
        rcnt[q] = rcnt[q] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    case (p)
      1: begin bus.req1_cmd_in = c; bus.req1_data_in = d; bus.req1_tag_in = t; end
      2: begin bus.req2_cmd_in = c; bus.req2_data_in = d; bus.req2_tag_in = t; end
      3: begin bus.req3_cmd_in = c; bus.req3_data_in = d; bus.req3_tag_in = t; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; bus.req4_tag_in = t; end
    endcase
  endtask

  task automatic idle_all();
    for (int p = 1; p <= 4; p++) drive(p, 4'd0, 32'd0, 2'd0);
  endtask

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    nvec++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One request on port p; cmd is repeated on the operand2 cycle and must be ignored.
  task automatic one(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] t, input logic [35:0] want, input string name);
    drive(p, c, a, t);
    tick();
    drive(p, c, b, t);
    tick();
    drive(p, 4'd0, 32'd0, 2'd0);
    tick();
    tick();
    chk({name, "_early"}, rsp(p), 36'd0);
    tick();
    chk(name, rsp(p), want);
    tick();
    chk({name, "_after"}, rsp(p), 36'd0);
  endtask

  initial begin
    logic [35:0] want;
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    for (int p = 1; p <= 4; p++) chk("reset_out", rsp(p), 36'd0);
    reset = 1'b0;
    tick();

    one(1, 4'd1, 32'h30, 32'h20, 2'd1, {2'd1, 2'd1, 32'h50}, "p1_add");
    one(2, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, {2'd2, 2'd2, 32'h0}, "p2_add_ovf");
    one(2, 4'd2, 32'h5, 32'h6, 2'd0, {2'd2, 2'd0, 32'h0}, "p2_sub_udf");
    one(2, 4'd2, 32'h6, 32'h6, 2'd1, {2'd1, 2'd1, 32'h0}, "p2_sub_eq");
    one(2, 4'd2, 32'h9, 32'h2, 2'd3, {2'd1, 2'd3, 32'h7}, "p2_sub");
    one(3, 4'd5, 32'h1, 32'h1F, 2'd0, {2'd1, 2'd0, 32'h8000_0000}, "p3_shl");
    one(3, 4'd6, 32'h8000_0000, 32'h24, 2'd1, {2'd1, 2'd1, 32'h0800_0000}, "p3_shr");

    // All four ports add together: one add unit serves them port1..4 on successive cycles.
    do_reset();
    for (int p = 1; p <= 4; p++) drive(p, 4'd1, 32'(p * 16), 2'(p - 1));
    tick();
    for (int p = 1; p <= 4; p++) drive(p, 4'd0, 32'h1, 2'd0);
    tick();
    idle_all();
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int p = 1; p <= 4; p++) begin
        want = (p == c + 1) ? {2'd1, 2'(p - 1), 32'(p * 16 + 1)} : 36'd0;
        chk("all4_add", rsp(p), want);
      end
    end

    // Add on port1 and shift on port2 use different units and finish together.
    drive(1, 4'd1, 32'h3, 2'd2);
    drive(2, 4'd5, 32'h3, 2'd3);
    tick();
    drive(1, 4'd0, 32'h4, 2'd0);
    drive(2, 4'd0, 32'h2, 2'd0);
    tick();
    idle_all();
    tick();
    tick();
    tick();
    chk("mixed_p1", rsp(1), {2'd1, 2'd2, 32'h7});
    chk("mixed_p2", rsp(2), {2'd1, 2'd3, 32'hC});

    // Port4 back-to-back: request k answers after edge 2k+4.
    for (int c = 0; c < 12; c++) begin
      if (c / 2 < 4) begin
        if (c % 2 == 0) drive(4, 4'd1, 32'(32'h1000 + c / 2), 2'(c / 2));
        else            drive(4, 4'd0, 32'h20, 2'd0);
      end else drive(4, 4'd0, 32'd0, 2'd0);
      tick();
      if (c >= 4 && c % 2 == 0 && (c - 4) / 2 < 4)
        want = {2'd1, 2'((c - 4) / 2), 32'(32'h1020 + (c - 4) / 2)};
      else
        want = 36'd0;
      chk("p4_b2b", rsp(4), want);
    end

    // Contention: ports 1-3 issue 7 adds, port4 issues 8 one cycle later.
    // Port4's queue is full with no pop when its 8th request arrives, so that one is lost.
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 45; c++) begin
      for (int p = 1; p <= 3; p++) begin
        if (c / 2 < 7) begin
          if (c % 2 == 0) drive(p, 4'd1, 32'(p * 256 + c / 2), 2'((c / 2) % 4));
          else            drive(p, 4'd0, 32'h10000, 2'd0);
        end else drive(p, 4'd0, 32'd0, 2'd0);
      end
      if (c >= 1 && (c - 1) / 2 < 8) begin
        if ((c - 1) % 2 == 0) drive(4, 4'd1, 32'(32'h400 + (c - 1) / 2), 2'(((c - 1) / 2) % 4));
        else                  drive(4, 4'd0, 32'h10000, 2'd0);
      end else drive(4, 4'd0, 32'd0, 2'd0);
      tick();
    end
    for (int q = 0; q < 4; q++) chk("full_count", 36'(rcnt[q]), 36'd7);
    for (int j = 0; j < 7; j++) chk("full_p4_order", rlog[3][j], {2'd1, 2'(j % 4), 32'(32'h10400 + j)});
    chk("full_p1_last", rlog[0][6], {2'd1, 2'd2, 32'h10106});
    mon_en = 1'b0;

    // Reset lands while port2's response is due and port1 waits for operand2.
    do_reset();
    drive(2, 4'd1, 32'h11, 2'd1);
    tick();
    drive(2, 4'd0, 32'h22, 2'd0);
    tick();
    drive(2, 4'd0, 32'd0, 2'd0);
    tick();
    drive(1, 4'd1, 32'h5, 2'd1);
    tick();
    drive(1, 4'd0, 32'h7, 2'd0);
    reset = 1'b1;
    tick();
    for (int p = 1; p <= 4; p++) chk("reset_mid_out", rsp(p), 36'd0);
    reset = 1'b0;
    idle_all();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("reset_mid_p1", rsp(1), 36'd0);
      chk("reset_mid_p2", rsp(2), 36'd0);
    end

`ifdef CALC2_INVALID_CMD_RESP_EN
    want = {2'd2, 2'd3, 32'h0};
`else
    want = 36'd0;
`endif
    one(1, 4'd3, 32'h12, 32'h34, 2'd3, want, "p1_invalid");
    one(1, 4'd1, 32'h1, 32'h2, 2'd0, {2'd1, 2'd0, 32'h3}, "p1_after_invalid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
